// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: WIDTH-bit pipeline stage with valid/ready handshake and a
// 2-entry skid buffer; sustains 1 transfer/cycle with registered in_ready.
// Latency 1 cycle in_fire -> out_valid. Backpressure: in_ready drops the cycle
// after the skid slot fills; it never depends combinationally on out_ready.
//
// Ports:
//   clock, reset     rising-edge clock; synchronous active-high reset (top priority)
//   flush            synchronous discard of all held entries (data regs untouched)
//   in_valid/in_ready/in_data     upstream handshake; in_ready is a flop
//   out_valid/out_ready/out_data  downstream handshake; out_valid, out_data are flops
//   occupancy        number of held entries, 0..2
module pipe_reg_skid #(
  parameter int unsigned            WIDTH       = 32,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  logic             in_fire;
  logic             out_fire;
  logic             main_we;
  logic             main_from_skid;
  logic             skid_we;

  // Handshakes are evaluated from registered flags only, so the in_ready flop
  // is the sole source of upstream backpressure.
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Next-state and data-register write enables.
  always_comb begin
    state_d        = state_q;
    main_we        = 1'b0;
    main_from_skid = 1'b0;
    skid_we        = 1'b0;

    if (flush) begin
      // Everything held is dropped; data registers keep their contents so
      // out_data simply holds while out_valid falls.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_we = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            // Head leaves while the new word replaces it: stay at one entry.
            main_we = 1'b1;
          end else if (in_fire) begin
            // Head is stalled; park the new word in the skid slot.
            skid_we = 1'b1;
            state_d = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so in_fire cannot occur.
          if (out_fire) begin
            main_we        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and handshake flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != TWO);
    end
  end

  // Data registers: main is the head, skid holds the second entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      if (main_we) begin
        main_q <= main_from_skid ? skid_q : in_data;
      end
      if (skid_we) begin
        skid_q <= in_data;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed bench for pipe_reg_skid: two instances (32-bit / 8-bit) driven
// with hand-computed vectors; outputs sampled 1 time unit after each edge.
module tb_pipe_reg_skid;

  logic        clock;
  int          n_chk;
  int          n_pass;

  // Instance A: WIDTH=32, RESET_VALUE=DEADBEEF
  logic        a_reset, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;

  // Instance B: WIDTH=8, RESET_VALUE=3C
  logic        b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_data, b_out_data;
  logic [1:0]  b_occ;

  pipe_reg_skid #(.WIDTH(32), .RESET_VALUE(32'hDEADBEEF)) u_a (
    .clock     (clock),
    .reset     (a_reset),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .occupancy (a_occ)
  );

  pipe_reg_skid #(.WIDTH(8), .RESET_VALUE(8'h3C)) u_b (
    .clock     (clock),
    .reset     (b_reset),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .occupancy (b_occ)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Check all A outputs in one call.
  task automatic check_a(input string tag, input logic vld, input logic rdy,
                         input logic [1:0] occ, input logic [31:0] dat);
    check({tag, " out_valid"}, {31'd0, a_out_valid}, {31'd0, vld});
    check({tag, " in_ready"},  {31'd0, a_in_ready},  {31'd0, rdy});
    check({tag, " occupancy"}, {30'd0, a_occ},       {30'd0, occ});
    check({tag, " out_data"},  a_out_data,           dat);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    a_reset = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
    b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;

    // Reset for two cycles, then idle.
    tick(); tick();
    a_reset = 1'b0; b_reset = 1'b0;
    check_a("reset", 1'b0, 1'b1, 2'd0, 32'hDEADBEEF);
    tick();
    check_a("idle", 1'b0, 1'b1, 2'd0, 32'hDEADBEEF);

    // Streaming 1,2,3 with out_ready=1.
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_in_data = 32'(i);
      tick();
      check_a($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 32'(i));
    end
    a_in_valid = 1'b0;
    tick();
    check_a("stream drain", 1'b0, 1'b1, 2'd0, 32'h3);

    // Back-pressure: A then B fill both slots, C is refused.
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'hA;
    tick();
    check_a("bp A", 1'b1, 1'b1, 2'd1, 32'hA);
    a_in_data = 32'hB;
    tick();
    check_a("bp full", 1'b1, 1'b0, 2'd2, 32'hA);
    a_in_data = 32'hC;
    tick();
    check_a("bp hold", 1'b1, 1'b0, 2'd2, 32'hA);
    a_out_ready = 1'b1;
    tick();
    check_a("bp outB", 1'b1, 1'b1, 2'd1, 32'hB);
    tick();
    check_a("bp outC", 1'b1, 1'b1, 2'd1, 32'hC);
    a_in_valid = 1'b0;
    tick();
    check_a("bp drain", 1'b0, 1'b1, 2'd0, 32'hC);

    // Simultaneous in_fire and out_fire in ONE.
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h5;
    tick();
    check_a("sim hold5", 1'b1, 1'b1, 2'd1, 32'h5);
    a_out_ready = 1'b1;
    a_in_data   = 32'h6;
    tick();
    check_a("sim swap6", 1'b1, 1'b1, 2'd1, 32'h6);
    a_in_valid = 1'b0;
    tick();
    check_a("sim drain", 1'b0, 1'b1, 2'd0, 32'h6);

    // Flush in TWO with out_ready high.
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h7;
    tick();
    a_in_data = 32'h8;
    tick();
    check_a("fl full", 1'b1, 1'b0, 2'd2, 32'h7);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    a_flush     = 1'b1;
    tick();
    a_flush = 1'b0;
    check_a("flush", 1'b0, 1'b1, 2'd0, 32'h7);
    tick();
    check_a("fl idle", 1'b0, 1'b1, 2'd0, 32'h7);
    a_in_valid = 1'b1;
    a_in_data  = 32'h9;
    tick();
    check_a("fl next9", 1'b1, 1'b1, 2'd1, 32'h9);
    a_in_valid = 1'b0;
    tick();
    check_a("fl drain", 1'b0, 1'b1, 2'd0, 32'h9);

    // Reset priority on A (32-bit).
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h11;
    tick();
    a_in_data = 32'h22;
    tick();
    check_a("rp full", 1'b1, 1'b0, 2'd2, 32'h11);
    a_reset = 1'b1; a_flush = 1'b1; a_out_ready = 1'b1; a_in_data = 32'h33;
    tick();
    a_reset = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0;
    check_a("rp reset", 1'b0, 1'b1, 2'd0, 32'hDEADBEEF);

    // Reset priority on B (8-bit).
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_data   = 8'h55;
    tick();
    b_in_data = 8'h66;
    tick();
    check("b full occ",  {30'd0, b_occ}, 32'd2);
    check("b full data", {24'd0, b_out_data}, 32'h55);
    check("b full rdy",  {31'd0, b_in_ready}, 32'd0);
    b_reset = 1'b1; b_flush = 1'b1; b_out_ready = 1'b1; b_in_data = 8'h77;
    tick();
    b_reset = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0;
    check("b rst occ",   {30'd0, b_occ}, 32'd0);
    check("b rst data",  {24'd0, b_out_data}, 32'h3C);
    check("b rst vld",   {31'd0, b_out_valid}, 32'd0);
    check("b rst rdy",   {31'd0, b_in_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
